// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port 2 between the CPU load/store path (A)
// and the loader/debug DMA engine (B).
//
// Build option RAM_ARB_ROUND_ROBIN_EN:
//   defined   - round-robin between A and B on contention (lastGrant based);
//               the B wait counter is compiled out.
//   undefined - fixed A-over-B priority; B overrides A after waiting 15 cycles.
//
// The granted request drives the RAM port combinationally; load data coming
// back from the RAM is registered into the owner's response register.

package base;
  typedef logic [31:0] cpu_word;
  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_BYTE_U = 3'd1,
    MEM_HALF   = 3'd2,
    MEM_HALF_U = 3'd3,
    MEM_WORD   = 3'd4
  } mem_mode;
endpackage

module ram_port_arbiter
  import base::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              aValid,
  output logic              aReady,
  input  logic [ADDR_W-1:0] aAddress,
  input  mem_mode           aMode,
  input  logic              aIsStore,
  input  cpu_word           aWdata,
  output logic              aRspValid,
  output cpu_word           aRdata,

  input  logic              bValid,
  output logic              bReady,
  input  logic [ADDR_W-1:0] bAddress,
  input  mem_mode           bMode,
  input  logic              bIsStore,
  input  cpu_word           bWdata,
  output logic              bRspValid,
  output cpu_word           bRdata,

  output logic [ADDR_W-1:0] ramAddress,
  output mem_mode           ramMode,
  output logic              ramIsStore,
  output cpu_word           ramWdata,
  input  cpu_word           ramRdata
);

  logic              grant_a;
  logic              grant_b;
  logic              last_grant_b;
  logic [ADDR_W-1:0] hold_address;
  mem_mode           hold_mode;
  cpu_word           hold_wdata;

`ifndef RAM_ARB_ROUND_ROBIN_EN
  logic [3:0] b_wait;
`endif

  // Pick at most one requester per cycle; nothing is granted while in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (aValid && bValid) begin
        grant_a = last_grant_b;
        grant_b = !last_grant_b;
      end else begin
        grant_a = aValid;
        grant_b = bValid;
      end
`else
      if (bValid && (!aValid || b_wait == 4'd15)) begin
        grant_b = 1'b1;
      end else begin
        grant_a = aValid;
      end
`endif
    end
  end

  assign aReady = grant_a;
  assign bReady = grant_b;

  // RAM port mirrors the granted request; when idle, the last fields are held
  // so the address/data buses do not toggle needlessly.
  always_comb begin
    ramAddress = hold_address;
    ramMode    = hold_mode;
    ramWdata   = hold_wdata;
    ramIsStore = 1'b0;
    if (grant_a) begin
      ramAddress = aAddress;
      ramMode    = aMode;
      ramWdata   = aWdata;
      ramIsStore = aIsStore;
    end else if (grant_b) begin
      ramAddress = bAddress;
      ramMode    = bMode;
      ramWdata   = bWdata;
      ramIsStore = bIsStore;
    end
  end

  // Remember the fields of the most recent grant for the idle-hold above.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_address <= '0;
      hold_mode    <= mem_mode'(3'd0);
      hold_wdata   <= '0;
    end else if (grant_a) begin
      hold_address <= aAddress;
      hold_mode    <= aMode;
      hold_wdata   <= aWdata;
    end else if (grant_b) begin
      hold_address <= bAddress;
      hold_mode    <= bMode;
      hold_wdata   <= bWdata;
    end
  end

  // Capture load data at the end of the grant cycle; valid pulses one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      aRspValid <= 1'b0;
      bRspValid <= 1'b0;
      aRdata    <= '0;
      bRdata    <= '0;
    end else begin
      aRspValid <= grant_a && !aIsStore;
      bRspValid <= grant_b && !bIsStore;
      if (grant_a && !aIsStore) aRdata <= ramRdata;
      if (grant_b && !bIsStore) bRdata <= ramRdata;
    end
  end

  // Track who was granted last; only steers selection in the round-robin build.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_b <= 1'b1;
    end else begin
      last_grant_b <= grant_b | (last_grant_b & ~grant_a);
    end
  end

`ifndef RAM_ARB_ROUND_ROBIN_EN
  // Count cycles B has been left waiting; saturates so the override sticks.
  always_ff @(posedge clk) begin
    if (rst || !bValid || grant_b) begin
      b_wait <= 4'd0;
    end else if (b_wait != 4'd15) begin
      b_wait <= b_wait + 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed test-plan steps followed by a
// randomized phase, all checked against a behavioural reference model.
module tb_ram_port_arbiter;
  import base::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        aValid, aReady, aIsStore, aRspValid;
  logic [31:0] aAddress;
  mem_mode     aMode;
  cpu_word     aWdata, aRdata;
  logic        bValid, bReady, bIsStore, bRspValid;
  logic [31:0] bAddress;
  mem_mode     bMode;
  cpu_word     bWdata, bRdata;
  logic [31:0] ramAddress;
  mem_mode     ramMode;
  logic        ramIsStore;
  cpu_word     ramWdata, ramRdata;

  ram_port_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aReady(aReady), .aAddress(aAddress), .aMode(aMode),
    .aIsStore(aIsStore), .aWdata(aWdata), .aRspValid(aRspValid), .aRdata(aRdata),
    .bValid(bValid), .bReady(bReady), .bAddress(bAddress), .bMode(bMode),
    .bIsStore(bIsStore), .bWdata(bWdata), .bRspValid(bRspValid), .bRdata(bRdata),
    .ramAddress(ramAddress), .ramMode(ramMode), .ramIsStore(ramIsStore),
    .ramWdata(ramWdata), .ramRdata(ramRdata)
  );

  always #5 clk = ~clk;

  // Environment RAM (stands in for ram_unit port 2) and the model's own copy.
  logic [7:0] env_mem [0:4095];
  logic [7:0] ref_mem [0:4095];

  function automatic cpu_word decode_load(logic [7:0] b0, logic [7:0] b1,
                                          logic [7:0] b2, logic [7:0] b3, mem_mode m);
    case (m)
      MEM_BYTE:   return {{24{b0[7]}}, b0};
      MEM_BYTE_U: return {24'h0, b0};
      MEM_HALF:   return {{16{b1[7]}}, b1, b0};
      MEM_HALF_U: return {16'h0, b1, b0};
      default:    return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic int nbytes(mem_mode m);
    if (m == MEM_WORD) return 4;
    if (m == MEM_HALF || m == MEM_HALF_U) return 2;
    return 1;
  endfunction

  logic [11:0] ea;
  assign ea = ramAddress[11:0];
  assign ramRdata = decode_load(env_mem[ea], env_mem[ea + 12'd1],
                                env_mem[ea + 12'd2], env_mem[ea + 12'd3], ramMode);

  always @(posedge clk) begin
    if (ramIsStore) begin
      for (int i = 0; i < nbytes(ramMode); i++)
        env_mem[ea + 12'(i)] <= ramWdata[8*i +: 8];
    end
  end

  // Reference model state
  int          n_cmp = 0;
  int          n_err = 0;
  bit          m_last_b;
  int          m_pending;
  bit          m_rsp_a, m_rsp_b;
  cpu_word     m_data_a, m_data_b;
  logic [31:0] m_hold_addr;
  mem_mode     m_hold_mode;
  cpu_word     m_hold_wdata;

  logic    obs_ar, obs_br, obs_arsp, obs_brsp, obs_st;
  cpu_word obs_ardata, obs_brdata;

  task automatic model_reset();
    m_last_b = 1'b1; m_pending = 0;
    m_rsp_a = 0; m_rsp_b = 0; m_data_a = '0; m_data_b = '0;
    m_hold_addr = '0; m_hold_mode = mem_mode'(3'd0); m_hold_wdata = '0;
  endtask

  function automatic cpu_word ref_load(logic [31:0] addr, mem_mode m);
    logic [11:0] a;
    a = addr[11:0];
    return decode_load(ref_mem[a], ref_mem[a + 12'd1], ref_mem[a + 12'd2],
                       ref_mem[a + 12'd3], m);
  endfunction

  task automatic ref_store(logic [31:0] addr, mem_mode m, cpu_word d);
    logic [11:0] a;
    a = addr[11:0];
    for (int i = 0; i < nbytes(m); i++) ref_mem[a + 12'(i)] = d[8*i +: 8];
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the DUT against the model mid-cycle, then advance.
  task automatic step(output bit ga, output bit gb);
    logic [31:0] e_addr;
    mem_mode     e_mode;
    cpu_word     e_wd;
    bit          e_st;
    @(negedge clk);
    ga = 0; gb = 0;
    if (!rst) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      if (aValid && bValid) begin
        if (m_last_b) ga = 1; else gb = 1;
      end else begin
        ga = aValid; gb = bValid;
      end
`else
      if (bValid && (m_pending >= 15 || !aValid)) gb = 1;
      else if (aValid) ga = 1;
`endif
    end
    e_addr = m_hold_addr; e_mode = m_hold_mode; e_wd = m_hold_wdata; e_st = 0;
    if (ga) begin e_addr = aAddress; e_mode = aMode; e_wd = aWdata; e_st = aIsStore; end
    if (gb) begin e_addr = bAddress; e_mode = bMode; e_wd = bWdata; e_st = bIsStore; end

    obs_ar = aReady; obs_br = bReady; obs_arsp = aRspValid; obs_brsp = bRspValid;
    obs_ardata = aRdata; obs_brdata = bRdata; obs_st = ramIsStore;

    chk("aReady", 64'(aReady), 64'(ga));
    chk("bReady", 64'(bReady), 64'(gb));
    chk("ramIsStore", 64'(ramIsStore), 64'(e_st));
    chk("ramAddress", 64'(ramAddress), 64'(e_addr));
    chk("ramMode", 64'(ramMode), 64'(e_mode));
    chk("ramWdata", 64'(ramWdata), 64'(e_wd));
    chk("aRspValid", 64'(aRspValid), 64'(m_rsp_a));
    chk("bRspValid", 64'(bRspValid), 64'(m_rsp_b));
    chk("aRdata", 64'(aRdata), 64'(m_data_a));
    chk("bRdata", 64'(bRdata), 64'(m_data_b));

    if (rst) begin
      model_reset();
    end else begin
      m_rsp_a = ga && !aIsStore;
      m_rsp_b = gb && !bIsStore;
      if (m_rsp_a) m_data_a = ref_load(aAddress, aMode);
      if (m_rsp_b) m_data_b = ref_load(bAddress, bMode);
      if (ga && aIsStore) ref_store(aAddress, aMode, aWdata);
      if (gb && bIsStore) ref_store(bAddress, bMode, bWdata);
      if (ga || gb) begin m_hold_addr = e_addr; m_hold_mode = e_mode; m_hold_wdata = e_wd; end
      if (bValid && !gb) m_pending++; else m_pending = 0;
      if (ga) m_last_b = 0;
      if (gb) m_last_b = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields(output logic [31:0] addr, output mem_mode m,
                             output logic st, output cpu_word d);
    m = mem_mode'($urandom_range(0, 4));
    addr = 32'($urandom_range(0, 255));
    if (m == MEM_WORD) addr[1:0] = 2'b00;
    else if (m == MEM_HALF || m == MEM_HALF_U) addr[0] = 1'b0;
    st = ($urandom_range(0, 2) == 0);
    d = $urandom;
  endtask

  initial begin
    bit ga, gb;
    for (int i = 0; i < 4096; i++) begin env_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    model_reset();

    // Reset held 3 cycles with both requesters valid
    rst = 1;
    aValid = 1; aAddress = 32'h40; aMode = MEM_WORD; aIsStore = 0; aWdata = 32'h0;
    bValid = 1; bAddress = 32'h80; bMode = MEM_WORD; bIsStore = 0; bWdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      step(ga, gb);
      chk("rst_no_grant", 64'({obs_ar, obs_br}), 64'(2'b00));
    end
    rst = 0;
    step(ga, gb);
    chk("post_rst_first_grant", 64'({obs_ar, obs_br}), 64'(2'b10));
    aValid = 0; bValid = 0;
    step(ga, gb);

    // Store then load from A
    aValid = 1; aAddress = 32'h100; aMode = MEM_WORD; aIsStore = 1; aWdata = 32'hDEADBEEF;
    step(ga, gb);
    aIsStore = 0; aWdata = 32'h0;
    step(ga, gb);
    aValid = 0;
    step(ga, gb);
    chk("st_ld_rsp", 64'(obs_arsp), 64'(1));
    chk("st_ld_data", 64'(obs_ardata), 64'(32'hDEADBEEF));

    // Cross-requester coherence: B byte store, A word load next cycle
    aValid = 1; aAddress = 32'h200; aMode = MEM_WORD; aIsStore = 1; aWdata = 32'h11223344;
    step(ga, gb);
    aValid = 0;
    bValid = 1; bAddress = 32'h203; bMode = MEM_BYTE; bIsStore = 1; bWdata = 32'h0000005A;
    step(ga, gb);
    bValid = 0;
    aValid = 1; aAddress = 32'h200; aMode = MEM_WORD; aIsStore = 0;
    step(ga, gb);
    chk("coh_b_rsp", 64'(obs_brsp), 64'(0));
    aValid = 0;
    step(ga, gb);
    chk("coh_data", 64'(obs_ardata), 64'(32'h5A223344));
    chk("coh_b_rsp2", 64'(obs_brsp), 64'(0));

    // Withdrawal: B-only grant, then B loses once while storing and drops
    bValid = 1; bAddress = 32'h300; bMode = MEM_WORD; bIsStore = 0;
    step(ga, gb);
    aValid = 1; aAddress = 32'h304; aMode = MEM_WORD; aIsStore = 0;
    bAddress = 32'h308; bIsStore = 1; bWdata = 32'hCAFEF00D;
    step(ga, gb);
    chk("wd_no_b_grant", 64'(obs_br), 64'(0));
    chk("wd_no_store", 64'(obs_st), 64'(0));
    bValid = 0; bIsStore = 0;
    step(ga, gb);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    // Contention: start from a B grant so A is next
    aValid = 0; bValid = 1;
    step(ga, gb);
    aValid = 1;
    for (int c = 0; c < 6; c++) begin
      step(ga, gb);
      chk("rr_alternate", 64'({obs_ar, obs_br}), (c % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
    end
`else
    // Starvation: B wins only after 15 lost cycles; the counter then restarts
    aValid = 1; bValid = 1; bAddress = 32'h308; bIsStore = 0;
    for (int c = 0; c < 32; c++) begin
      step(ga, gb);
      chk("starve_b", 64'(obs_br), 64'(c == 15 || c == 31));
    end
`endif
    aValid = 0; bValid = 0;
    step(ga, gb);

    // Randomized traffic with occasional withdrawals and resets
    for (int c = 0; c < 3000; c++) begin
      if (!(aValid && !obs_ar && $urandom_range(0, 9) != 0)) begin
        aValid = ($urandom_range(0, 9) < 7);
        rand_fields(aAddress, aMode, aIsStore, aWdata);
      end
      if (!(bValid && !obs_br && $urandom_range(0, 9) != 0)) begin
        bValid = ($urandom_range(0, 9) < 7);
        rand_fields(bAddress, bMode, bIsStore, bWdata);
      end
      rst = ($urandom_range(0, 99) == 0);
      step(ga, gb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
